pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL take parameter WIDTH, default 12, which sets the program-counter width in bits.
REQ-002 The module SHALL take parameter STEP, default 1, which sets the sequential increment (unsigned, less than 2^WIDTH).
REQ-003 The module SHALL take parameter RESET_ADDR, default 0, which sets the PC value loaded on reset.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-005 The module SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port stall, input, 1 bit: hold PC this cycle.
REQ-007 The module SHALL have port halt_req, input, 1 bit: request entry to HALT.
REQ-008 The module SHALL have port resume, input, 1 bit: request exit from HALT.
REQ-009 The module SHALL have port jump_valid, input, 1 bit: absolute jump request.
REQ-010 The module SHALL have port jump_target, input, WIDTH bits: absolute jump address.
REQ-011 The module SHALL have port branch_valid, input, 1 bit: relative branch request.
REQ-012 The module SHALL have port branch_offset, input, WIDTH bits: two's-complement branch offset.
REQ-013 The module SHALL have port pc, output, WIDTH bits: the registered current PC.
REQ-014 The module SHALL have port pc_seq, output, WIDTH bits: combinational (pc + STEP) mod 2^WIDTH.
REQ-015 The module SHALL have port halted, output, 1 bit: high while the FSM is in HALT.
REQ-016 The module SHALL have port wrapped, output, 1 bit: sticky flag for a sequential-increment wrap.

Function
REQ-017 The FSM SHALL have exactly two states, RUN and HALT; halted SHALL equal (state == HALT).
REQ-018 In RUN with halt_req=1, at the next edge the state SHALL become HALT and pc SHALL hold, regardless of stall, jump_valid, branch_valid or resume.
REQ-019 In HALT with resume=1, at the next edge the state SHALL become RUN and pc SHALL hold; halt_req, jump_valid and branch_valid SHALL be ignored in HALT.
REQ-020 In HALT with resume=0, the state and pc SHALL hold.
REQ-021 In RUN with halt_req=0, the pc update SHALL use fixed priority: stall (hold), then jump_valid, then branch_valid, then sequential.
REQ-022 A jump SHALL load pc <= jump_target.
REQ-023 A branch SHALL load pc <= (pc + STEP + branch_offset) mod 2^WIDTH, with the offset sign-interpreted.
REQ-024 The sequential case SHALL load pc <= pc_seq.
REQ-025 All PC arithmetic SHALL be WIDTH bits, modulo 2^WIDTH; no output SHALL saturate.
REQ-026 wrapped SHALL be set at any edge where a sequential update is taken and pc + STEP >= 2^WIDTH (carry out).
REQ-027 wrapped SHALL remain set until reset; jumps and branches SHALL NOT set or clear it.
REQ-028 Every request SHALL take effect exactly one edge after it is sampled (latency 1); no request SHALL be queued or remembered.
REQ-029 pc_seq SHALL track pc combinationally with zero latency.

Reset
REQ-030 While reset_n=0, independent of clock: pc = RESET_ADDR, state = RUN, halted = 0, wrapped = 0.
REQ-031 An assertion of reset_n mid-operation (including in HALT, or during a jump or branch) SHALL abort it immediately, with no residual state.
REQ-032 The first update after reset_n deasserts SHALL occur at the first rising edge with reset_n=1.

Verification
REQ-033 Reset, then 3 idle cycles (WIDTH=12, STEP=1) -> pc = 0x000, 0x001, 0x002, 0x003; halted = 0; wrapped = 0.
REQ-034 pc=0xFFE, sequential for 2 cycles -> pc = 0xFFF, then 0x000; wrapped rises at the 0x000 edge and stays 1 after a jump to 0x100.
REQ-035 pc=0x010, branch_offset=0xFFC (-4) -> pc = 0x00D; pc=0x010 with jump_valid, jump_target=0x200 and branch_valid asserted together -> pc = 0x200.
REQ-036 pc=0x020, stall=1 and jump_valid=1 -> pc = 0x020; release stall with jump_valid still 1 -> pc = jump_target.
REQ-037 pc=0x040, halt_req=1 -> halted = 1, pc = 0x040; jump_valid=1 while halted -> pc holds; resume=1 -> halted = 0, pc = 0x040; next idle cycle -> pc = 0x041.
REQ-038 Assert reset_n low mid-cycle while halted at pc=0x123 -> pc = 0x000 and halted = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with a RUN/HALT control FSM.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   stall          hold pc this cycle (RUN only)
//   halt_req       enter HALT at the next edge (RUN only)
//   resume         leave HALT at the next edge (HALT only)
//   jump_valid     load jump_target
//   jump_target    absolute jump address
//   branch_valid   load pc + STEP + branch_offset
//   branch_offset  two's-complement branch offset
//   pc             registered program counter
//   pc_seq         combinational pc + STEP, modulo 2^WIDTH
//   halted         high while in HALT
//   wrapped        sticky: a sequential increment carried out of the top bit
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | pc advances: stall > jump > branch > sequential
// ST_HALT | pc frozen; only resume is observed

module pc_unit #(
   parameter int WIDTH      = 12,
   parameter int STEP       = 1,
   parameter int RESET_ADDR = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             jump_valid,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             branch_valid,
   input  logic [WIDTH-1:0] branch_offset,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_seq,
   output logic             halted,
   output logic             wrapped
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_ADDR);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic             wrapped_nxt;
   logic [WIDTH:0]   seq_sum;
   logic             seq_carry;
   logic [WIDTH-1:0] branch_addr;

   // One extra bit captures the carry that marks a wrap.
   assign seq_sum     = {1'b0, pc} + {1'b0, STEP_W};
   assign pc_seq      = seq_sum[WIDTH-1:0];
   assign seq_carry   = seq_sum[WIDTH];
   // Modulo add: two's-complement offset needs no explicit sign extension.
   assign branch_addr = pc_seq + branch_offset;
   assign halted      = (state == ST_HALT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_RUN;
         pc      <= RESET_W;
         wrapped <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         wrapped <= wrapped_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      wrapped_nxt = wrapped;
      case (state)
         ST_RUN: begin
            if (halt_req) begin
               state_nxt = ST_HALT;
            end else if (stall) begin
               pc_nxt = pc;
            end else if (jump_valid) begin
               pc_nxt = jump_target;
            end else if (branch_valid) begin
               pc_nxt = branch_addr;
            end else begin
               pc_nxt = pc_seq;
               if (seq_carry) begin
                  wrapped_nxt = 1'b1;
               end
            end
         end
         ST_HALT: begin
            if (resume) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   localparam int W    = 12;
   localparam int STEP = 1;
   localparam int MOD  = 1 << W;

   logic          clock;
   logic          reset_n;
   logic          stall, halt_req, resume, jump_valid, branch_valid;
   logic [W-1:0]  jump_target, branch_offset;
   logic [W-1:0]  pc, pc_seq;
   logic          halted, wrapped;

   int n_checks = 0;
   int n_fail   = 0;

   int m_pc;
   bit m_halted;
   bit m_wrapped;

   pc_unit #(.WIDTH(W), .STEP(STEP), .RESET_ADDR(0)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall         (stall),
      .halt_req      (halt_req),
      .resume        (resume),
      .jump_valid    (jump_valid),
      .jump_target   (jump_target),
      .branch_valid  (branch_valid),
      .branch_offset (branch_offset),
      .pc            (pc),
      .pc_seq        (pc_seq),
      .halted        (halted),
      .wrapped       (wrapped)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 0;
      m_halted  = 0;
      m_wrapped = 0;
   endtask

   // Reference behaviour: what one rising edge does, from the rules directly.
   task automatic model_step();
      int off;
      if (m_halted) begin
         if (resume) m_halted = 0;
      end else if (halt_req) begin
         m_halted = 1;
      end else if (stall) begin
         // hold
      end else if (jump_valid) begin
         m_pc = int'(jump_target);
      end else if (branch_valid) begin
         off = int'(branch_offset);
         if (off >= MOD / 2) off = off - MOD;
         m_pc = ((m_pc + STEP + off) % MOD + MOD) % MOD;
      end else begin
         if (m_pc + STEP >= MOD) m_wrapped = 1;
         m_pc = (m_pc + STEP) % MOD;
      end
   endtask

   task automatic check_all();
      check("pc",      32'(pc),      32'(m_pc));
      check("pc_seq",  32'(pc_seq),  32'((m_pc + STEP) % MOD));
      check("halted",  32'(halted),  32'(m_halted));
      check("wrapped", 32'(wrapped), 32'(m_wrapped));
   endtask

   task automatic idle();
      stall = 0; halt_req = 0; resume = 0; jump_valid = 0; branch_valid = 0;
      jump_target = '0; branch_offset = '0;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_all();
   endtask

   task automatic go_to(input int addr);
      idle();
      jump_valid  = 1;
      jump_target = W'(addr);
      cycle();
      idle();
   endtask

   // Reset asserted between edges, checked before any edge arrives.
   task automatic async_reset(input string tag);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      check({tag, "_pc"},     32'(pc),     32'h0);
      check({tag, "_halted"}, 32'(halted), 32'h0);
      check({tag, "_wrap"},   32'(wrapped), 32'h0);
      @(negedge clock);
      check_all();
      reset_n = 1;
   endtask

   initial begin
      idle();
      reset_n = 0;
      model_reset();
      #12;
      check("rst_pc",     32'(pc),      32'h0);
      check("rst_halted", 32'(halted),  32'h0);
      check("rst_wrap",   32'(wrapped), 32'h0);
      check("rst_pc_seq", 32'(pc_seq),  32'h1);
      @(negedge clock);
      reset_n = 1;

      // three idle cycles
      for (int i = 1; i <= 3; i++) begin
         cycle();
         check("idle_pc", 32'(pc), 32'(i));
      end
      check("idle_wrap", 32'(wrapped), 32'h0);

      // wrap at top of range, sticky through a jump
      go_to(12'hFFE);
      cycle();
      check("wrap_fff", 32'(pc), 32'hFFF);
      check("wrap_pre", 32'(wrapped), 32'h0);
      cycle();
      check("wrap_000", 32'(pc), 32'h000);
      check("wrap_set", 32'(wrapped), 32'h1);
      go_to(12'h100);
      check("wrap_jump_pc", 32'(pc), 32'h100);
      check("wrap_sticky",  32'(wrapped), 32'h1);

      // backward branch
      go_to(12'h010);
      branch_valid = 1; branch_offset = 12'hFFC;
      cycle();
      check("branch_neg", 32'(pc), 32'h00D);

      // jump beats branch
      go_to(12'h010);
      jump_valid = 1; jump_target = 12'h200; branch_valid = 1; branch_offset = 12'h005;
      cycle();
      check("jump_prio", 32'(pc), 32'h200);

      // stall beats jump
      go_to(12'h020);
      stall = 1; jump_valid = 1; jump_target = 12'h345;
      cycle();
      check("stall_hold", 32'(pc), 32'h020);
      stall = 0;
      cycle();
      check("stall_rel", 32'(pc), 32'h345);

      // halt / resume
      go_to(12'h040);
      halt_req = 1; jump_valid = 1; jump_target = 12'h777;
      cycle();
      check("halt_in",    32'(halted), 32'h1);
      check("halt_pc",    32'(pc),     32'h040);
      idle();
      jump_valid = 1; jump_target = 12'h300; branch_valid = 1; halt_req = 1;
      cycle();
      check("halt_ign",   32'(pc),     32'h040);
      idle();
      resume = 1; jump_valid = 1; jump_target = 12'h300;
      cycle();
      check("resume_out", 32'(halted), 32'h0);
      check("resume_pc",  32'(pc),     32'h040);
      idle();
      cycle();
      check("resume_seq", 32'(pc),     32'h041);

      // async reset while halted
      go_to(12'h123);
      halt_req = 1;
      cycle();
      idle();
      check("pre_rst_halt", 32'(halted), 32'h1);
      async_reset("areset_halt");

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         stall         = ($urandom % 4) == 0;
         halt_req      = ($urandom % 10) == 0;
         resume        = ($urandom % 3) == 0;
         jump_valid    = ($urandom % 6) == 0;
         branch_valid  = ($urandom % 3) == 0;
         jump_target   = ($urandom % 4 == 0) ? W'(MOD - 1 - ($urandom % 4)) : W'($urandom);
         branch_offset = W'($urandom);
         if (($urandom % 250) == 0) begin
            idle();
            async_reset("areset_rand");
         end else begin
            cycle();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
